// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART receive framer for uart_lite.
// Synchronises the serial line and finds the start bit. Recovers 5..9 data bits (LSB first),
// optional parity and 1 or 2 stop bits with a 3-sample mid-bit majority vote.
// Each character is presented with its error flags in a one-entry valid/ready output register.
// Optional feature macro: UART_RX_FRAMER_BREAK_DETECT_EN (line-break detection on break_o).
module uart_rx_framer #(
  parameter int   OVERSAMPLING  = 16,
  parameter logic IDLE_POLARITY = 1'b1,
  parameter int   DATA_BITS     = 8,
  parameter int   PARITY_MODE   = 0,
  parameter int   STOP_BITS     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] char_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  output logic                 break_o
);

  localparam int                CNT_W         = $clog2(OVERSAMPLING);
  localparam logic [CNT_W-1:0]  BIT_RELOAD    = CNT_W'(OVERSAMPLING - 1);
  localparam logic [CNT_W-1:0]  HALF_RELOAD   = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_TWO       = CNT_W'(2);
  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
  localparam logic              ACTIVE_LEVEL  = ~IDLE_POLARITY;
  localparam logic [3:0]        LAST_DATA_IDX = 4'(DATA_BITS - 1);
  localparam logic              LAST_STOP_IDX = 1'(STOP_BITS - 1);
  localparam bit                PARITY_EN     = (PARITY_MODE != 0);
  localparam bit                PARITY_ODD    = (PARITY_MODE == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic                 rx_meta_q;
  logic                 rxs_q;
  logic                 rxs_prev_q;

  logic [CNT_W-1:0]     cnt_q;
  logic                 samp2_q;
  logic                 samp1_q;

  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 frm_err_q;

  logic                 vote;
  logic                 decide;
  logic                 start_edge;
  logic                 last_data;
  logic                 last_stop;
  logic                 frame_done;
  logic                 frm_err_fin;
  logic                 is_break;

  // The line is asynchronous: two flops for metastability, a third remembers the previous
  // synchronised level so an idle->active transition can be recognised.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q  <= IDLE_POLARITY;
      rxs_q      <= IDLE_POLARITY;
      rxs_prev_q <= IDLE_POLARITY;
    end else begin
      rx_meta_q  <= rx_i;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Samples taken at counter 2 and 1 combine with the live level at counter 0.
  assign vote        = (samp2_q & samp1_q) | (samp2_q & rxs_q) | (samp1_q & rxs_q);
  assign decide      = (state_q != ST_IDLE) && (cnt_q == '0);
  assign start_edge  = (rxs_prev_q == IDLE_POLARITY) && (rxs_q == ACTIVE_LEVEL);
  assign last_data   = (bit_idx_q == LAST_DATA_IDX);
  assign last_stop   = (stop_idx_q == LAST_STOP_IDX);
  assign frame_done  = (state_q == ST_STOP) && decide && last_stop;
  assign frm_err_fin = frm_err_q | (vote != IDLE_POLARITY);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every transition out of a bit state happens on a bit decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (decide) begin
          state_d = (vote == ACTIVE_LEVEL) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (decide && last_data) begin
          state_d = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (decide) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide && last_stop) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit timer and vote samples. The first wait is half a bit so decisions land mid-bit;
  // the samples are preloaded on the start edge so very small oversampling still votes sanely.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      samp2_q <= IDLE_POLARITY;
      samp1_q <= IDLE_POLARITY;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= start_edge ? HALF_RELOAD : '0;
      if (start_edge) begin
        samp2_q <= rxs_q;
        samp1_q <= rxs_q;
      end
    end else begin
      cnt_q <= (cnt_q == '0) ? BIT_RELOAD : (cnt_q - CNT_ONE);
      if (cnt_q == CNT_TWO) begin
        samp2_q <= rxs_q;
      end
      if (cnt_q == CNT_ONE) begin
        samp1_q <= rxs_q;
      end
    end
  end

  // Frame assembly: data shifts in from the top so the first bit ends up in bit 0;
  // parity and stop errors accumulate until the frame completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else if (decide) begin
      case (state_q)
        ST_START: begin
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          par_err_q  <= 1'b0;
          frm_err_q  <= 1'b0;
        end
        ST_DATA: begin
          shift_q   <= {vote, shift_q[DATA_BITS-1:1]};
          bit_idx_q <= bit_idx_q + 4'd1;
        end
        ST_PARITY: begin
          par_err_q <= PARITY_ODD ? ~((^shift_q) ^ vote) : ((^shift_q) ^ vote);
        end
        ST_STOP: begin
          frm_err_q  <= frm_err_fin;
          stop_idx_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef UART_RX_FRAMER_BREAK_DETECT_EN
  logic all_active_q;

  // Tracks whether every data, parity and stop vote so far has been the active level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      all_active_q <= 1'b0;
    end else if (decide) begin
      if (state_q == ST_START) begin
        all_active_q <= 1'b1;
      end else begin
        all_active_q <= all_active_q & (vote == ACTIVE_LEVEL);
      end
    end
  end

  assign is_break = all_active_q && (vote == ACTIVE_LEVEL);

  // Break indication rises after an all-active frame and drops once the line is seen idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      break_o <= 1'b0;
    end else if (frame_done && is_break) begin
      break_o <= 1'b1;
    end else if (rxs_q == IDLE_POLARITY) begin
      break_o <= 1'b0;
    end
  end
`else
  assign is_break = 1'b0;
  assign break_o  = 1'b0;
`endif

  // Output slot: a completed frame loads if the slot is empty or being drained this cycle,
  // otherwise it is dropped and reported. The held character never changes while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      char_o       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      valid_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (frame_done && !is_break) begin
        if (!valid_o || ready_i) begin
          char_o       <= shift_q;
          parity_err_o <= par_err_q;
          frame_err_o  <= frm_err_fin;
          valid_o      <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: self-checking bench for uart_rx_framer.
// Three instances (8N1, 7E1, 8N2) share one clock; each has its own line and ready.
// Expected characters and flags come from a frame builder/decoder working on bit lists.
`timescale 1ns/1ps
module tb_uart_rx_framer;

  localparam int OS = 16;

  typedef struct packed {
    logic [8:0] ch;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    int         idx;
    logic [8:0] ch;
    logic       pe;
    logic       fe;
    longint     cyc;
  } rec_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [2:0] rx_v;
  logic [2:0] ready_v;
  logic [2:0] valid_v, perr_v, ferr_v, ovr_v, brk_v;
  logic [7:0] ch0, ch2;
  logic [6:0] ch1;

  int     checks = 0;
  int     fails = 0;
  longint cyc = 0;
  longint startCyc = 0;
  int     ovrCnt [3] = '{0, 0, 0};
  int     nbitsOf [3] = '{8, 7, 8};
  int     pmodeOf [3] = '{0, 2, 0};
  int     nstopOf [3] = '{1, 1, 2};
  rec_t   got [$];
  rec_t   monRec;
  rec_t   lastRec;

  always #5 clk_i = ~clk_i;

  uart_rx_framer #(.OVERSAMPLING(OS), .IDLE_POLARITY(1'b1), .DATA_BITS(8),
                   .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_v[0]), .char_o(ch0),
    .parity_err_o(perr_v[0]), .frame_err_o(ferr_v[0]), .valid_o(valid_v[0]),
    .ready_i(ready_v[0]), .overrun_o(ovr_v[0]), .break_o(brk_v[0]));

  uart_rx_framer #(.OVERSAMPLING(OS), .IDLE_POLARITY(1'b1), .DATA_BITS(7),
                   .PARITY_MODE(2), .STOP_BITS(1)) u_7e1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_v[1]), .char_o(ch1),
    .parity_err_o(perr_v[1]), .frame_err_o(ferr_v[1]), .valid_o(valid_v[1]),
    .ready_i(ready_v[1]), .overrun_o(ovr_v[1]), .break_o(brk_v[1]));

  uart_rx_framer #(.OVERSAMPLING(OS), .IDLE_POLARITY(1'b1), .DATA_BITS(8),
                   .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_v[2]), .char_o(ch2),
    .parity_err_o(perr_v[2]), .frame_err_o(ferr_v[2]), .valid_o(valid_v[2]),
    .ready_i(ready_v[2]), .overrun_o(ovr_v[2]), .break_o(brk_v[2]));

  function automatic logic [8:0] charOf(input int idx);
    case (idx)
      0:       return {1'b0, ch0};
      1:       return {2'b00, ch1};
      default: return {1'b0, ch2};
    endcase
  endfunction

  // Line frame as a bit list (bit 0 sent first): start, data LSB first, parity, stops.
  function automatic logic [15:0] buildFrame(input logic [8:0] data, input int idx,
                                             input bit flipPar, input bit badStop,
                                             output int n);
    logic [15:0] f;
    int          k;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    k    = 1;
    p    = 1'b0;
    for (int i = 0; i < nbitsOf[idx]; i++) begin
      f[k] = data[i];
      p    = p ^ data[i];
      k++;
    end
    if (pmodeOf[idx] != 0) begin
      f[k] = ((pmodeOf[idx] == 1) ? ~p : p) ^ flipPar;
      k++;
    end
    for (int s = 0; s < nstopOf[idx]; s++) begin
      f[k] = !(badStop && (s == nstopOf[idx] - 1));
      k++;
    end
    n = k;
    return f;
  endfunction

  // What a receiver should report for a given bit list, from the framing rules alone.
  function automatic exp_t decodeFrame(input logic [15:0] f, input int idx);
    exp_t e;
    int   k;
    int   ones;
    e    = '0;
    ones = 0;
    k    = 1;
    for (int i = 0; i < nbitsOf[idx]; i++) begin
      e.ch[i] = f[k];
      ones    = ones + int'(f[k]);
      k++;
    end
    if (pmodeOf[idx] != 0) begin
      ones = ones + int'(f[k]);
      e.pe = (pmodeOf[idx] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      k++;
    end
    for (int s = 0; s < nstopOf[idx]; s++) begin
      if (f[k] == 1'b0) e.fe = 1'b1;
      k++;
    end
    return e;
  endfunction

  // Cycle counter used for latency measurement.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: record every completed transfer and count overrun pulses, away from the edge.
  always @(negedge clk_i) begin
    for (int i = 0; i < 3; i++) begin
      if (valid_v[i] && ready_v[i]) begin
        monRec.idx = i;
        monRec.ch  = charOf(i);
        monRec.pe  = perr_v[i];
        monRec.fe  = ferr_v[i];
        monRec.cyc = cyc;
        got.push_back(monRec);
      end
      if (ovr_v[i]) ovrCnt[i] = ovrCnt[i] + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one frame, one bit per OS cycles; optionally invert one cycle inside bit gbit.
  task automatic applyStimulus(input int idx, input logic [15:0] f, input int n,
                               input int gbit, input int goff);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < OS; c++) begin
        @(posedge clk_i); #1;
        if (b == 0 && c == 0) startCyc = cyc;
        rx_v[idx] = (b == gbit && c == goff) ? ~f[b] : f[b];
      end
    end
    @(posedge clk_i); #1;
    rx_v[idx] = 1'b1;
    repeat (4) @(posedge clk_i);
  endtask

  task automatic sendChar(input int idx, input logic [8:0] data, input bit flipPar,
                          input bit badStop, input int gbit, input int goff, output exp_t e);
    logic [15:0] f;
    int          n;
    f = buildFrame(data, idx, flipPar, badStop, n);
    e = decodeFrame(f, idx);
    applyStimulus(idx, f, n, gbit, goff);
  endtask

  task automatic expectFrame(input int idx, input exp_t e, input string tag);
    rec_t r;
    for (int w = 0; w < 400 && got.size() == 0; w++) @(negedge clk_i);
    checkOutput({tag, "_present"}, 32'(got.size() != 0), 32'd1);
    if (got.size() != 0) begin
      r       = got.pop_front();
      lastRec = r;
      checkOutput({tag, "_port"}, r.idx, idx);
      checkOutput({tag, "_char"}, 32'(r.ch), 32'(e.ch));
      checkOutput({tag, "_perr"}, 32'(r.pe), 32'(e.pe));
      checkOutput({tag, "_ferr"}, 32'(r.fe), 32'(e.fe));
    end
  endtask

  initial begin
    exp_t        e;
    exp_t        eHeld;
    logic [8:0]  d;
    longint      lat;
    int          ovrBase;
    logic [15:0] f;
    int          n;

    rx_v    = 3'b111;
    ready_v = 3'b111;
    rst_ni  = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_valid", 32'(valid_v), 32'd0);
    checkOutput("reset_char0", 32'(ch0), 32'd0);
    checkOutput("reset_flags", 32'({perr_v, ferr_v, ovr_v, brk_v}), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);

    $display("[TB] 8N1 0xA5 and latency");
    sendChar(0, 9'h0A5, 1'b0, 1'b0, -1, 0, e);
    expectFrame(0, e, "t1_a5");
    lat = lastRec.cyc - startCyc;
    checkOutput("t1_latency", 32'(lat >= 154 && lat <= 156), 32'd1);
    for (int i = 0; i < 4; i++) begin
      d = 9'($urandom_range(0, 255));
      sendChar(0, d, 1'b0, 1'b0, -1, 0, e);
      expectFrame(0, e, "t1_rand");
    end

    $display("[TB] 7E1 parity");
    sendChar(1, 9'h041, 1'b0, 1'b0, -1, 0, e);
    expectFrame(1, e, "t2_good");
    sendChar(1, 9'h041, 1'b1, 1'b0, -1, 0, e);
    expectFrame(1, e, "t2_flip");
    for (int i = 0; i < 4; i++) begin
      d = 9'($urandom_range(0, 127));
      sendChar(1, d, 1'($urandom_range(0, 1)), 1'b0, -1, 0, e);
      expectFrame(1, e, "t2_rand");
    end

    $display("[TB] 8N2 stop checking");
    d = 9'($urandom_range(0, 255));
    sendChar(2, d, 1'b0, 1'b1, -1, 0, e);
    expectFrame(2, e, "t3_badstop");
    sendChar(2, 9'h03C, 1'b0, 1'b0, -1, 0, e);
    expectFrame(2, e, "t3_3c");

    $display("[TB] Backpressure and overrun");
    @(posedge clk_i); #1;
    ready_v[0] = 1'b0;
    ovrBase    = ovrCnt[0];
    sendChar(0, 9'h011, 1'b0, 1'b0, -1, 0, eHeld);
    sendChar(0, 9'h022, 1'b0, 1'b0, -1, 0, e);
    @(negedge clk_i);
    checkOutput("t4_overrun_once", ovrCnt[0] - ovrBase, 32'd1);
    checkOutput("t4_valid_held", 32'(valid_v[0]), 32'd1);
    checkOutput("t4_char_held", 32'(ch0), 32'(eHeld.ch));
    checkOutput("t4_no_transfer", got.size(), 32'd0);
    @(posedge clk_i); #1;
    ready_v[0] = 1'b1;
    expectFrame(0, eHeld, "t4_drain");
    repeat (300) @(negedge clk_i);
    checkOutput("t4_no_second", got.size(), 32'd0);
    checkOutput("t4_valid_low", 32'(valid_v[0]), 32'd0);

    $display("[TB] Glitch rejection");
    @(posedge clk_i); #1;
    rx_v[0] = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rx_v[0] = 1'b1;
    repeat (60) @(negedge clk_i);
    checkOutput("t5_no_output", got.size(), 32'd0);
    checkOutput("t5_valid_low", 32'(valid_v[0]), 32'd0);
    sendChar(0, 9'h05A, 1'b0, 1'b0, $urandom_range(1, 8), $urandom_range(6, 8), e);
    expectFrame(0, e, "t5_5a");

    $display("[TB] Line held active");
    @(posedge clk_i); #1;
    rx_v[0] = 1'b0;
    repeat (250) @(posedge clk_i);
    @(negedge clk_i);
`ifdef UART_RX_FRAMER_BREAK_DETECT_EN
    checkOutput("t6_break_mid", 32'(brk_v[0]), 32'd1);
    checkOutput("t6_no_valid", 32'(valid_v[0]), 32'd0);
`else
    checkOutput("t6_break_mid", 32'(brk_v[0]), 32'd0);
`endif
    repeat (70) @(posedge clk_i);
    #1;
    rx_v[0] = 1'b1;
    repeat (10) @(negedge clk_i);
    checkOutput("t6_break_clear", 32'(brk_v[0]), 32'd0);
`ifdef UART_RX_FRAMER_BREAK_DETECT_EN
    checkOutput("t6_no_char", got.size(), 32'd0);
`else
    expectFrame(0, decodeFrame(16'h0000, 0), "t6_break_char");
    checkOutput("t6_single_char", got.size(), 32'd0);
`endif

    $display("[TB] Reset mid-frame");
    @(posedge clk_i); #1;
    ready_v[0] = 1'b0;
    sendChar(0, 9'h099, 1'b0, 1'b0, -1, 0, e);
    f = buildFrame(9'h077, 0, 1'b0, 1'b0, n);
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < OS; c++) begin
        @(posedge clk_i); #1;
        rx_v[0] = f[b];
      end
    end
    @(negedge clk_i);
    checkOutput("rst_pre_valid", 32'(valid_v[0]), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(valid_v), 32'd0);
    checkOutput("rst_char", 32'(ch0), 32'd0);
    checkOutput("rst_flags", 32'({perr_v, ferr_v, ovr_v, brk_v}), 32'd0);
    rx_v[0] = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    rst_ni     = 1'b1;
    ready_v[0] = 1'b1;
    repeat (5) @(posedge clk_i);
    sendChar(0, 9'h0C3, 1'b0, 1'b0, -1, 0, e);
    expectFrame(0, e, "rst_after");
    repeat (50) @(negedge clk_i);
    checkOutput("rst_no_extra", got.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
